// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: FSM states, address
// source encodings, strobe levels and counter sizing helper.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE   = 2'd0,
        RSP_ACCESS = 2'd1,
        RSP_RESP   = 2'd2
    } rsp_state_t;

    typedef enum logic {
        DST_PC  = 1'b0,
        DST_ALU = 1'b1
    } mem_dst_t;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam int SIZE_WORD = 16;

    // Bits needed to count from 0 up to and including n.
    function automatic int ctr_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts enabled cycles and flags the cycle on which the
// count would reach TIMEOUT, so the caller can abort on that same edge.
module mem_timeout_ctr
    import mem_responder_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CW = ctr_width(TIMEOUT);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_inc;

    assign w_count_inc = r_count + CW'(1);
    assign o_tc        = i_enable && (w_count_inc == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: runs one request from the control FSM against a
// variable-latency backing memory and returns a single completion pulse.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_W  = SIZE_WORD,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_read,
    input  logic              req_write,
    input  logic              req_dst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [WORD_W-1:0] inst_reg,
    output logic [WORD_W-1:0] mdr,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [WORD_W-1:0] m_wdata,
    input  logic [WORD_W-1:0] m_rdata,
    input  logic              m_ack
);

    rsp_state_t        r_state;
    rsp_state_t        w_state_next;

    logic              w_accept;
    logic              w_illegal;
    logic              w_ack_done;
    logic              w_timeout;
    logic              w_tc;
    logic              w_in_access;

    logic [ADDR_W-1:0] r_m_addr;
    logic [WORD_W-1:0] r_m_wdata;
    logic              r_m_rd;
    logic              r_m_wr;
    mem_dst_t          r_dst;
    logic              r_is_write;
    logic [WORD_W-1:0] r_inst;
    logic [WORD_W-1:0] r_mdr;
    logic              r_resp_err;

    assign w_in_access = (r_state == RSP_ACCESS);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (!w_in_access),
        .i_enable (w_in_access),
        .o_tc     (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RSP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An ack arriving on the watchdog's last cycle still counts as success.
    always_comb begin
        w_state_next = r_state;
        w_accept     = OFF;
        w_illegal    = OFF;
        w_ack_done   = OFF;
        w_timeout    = OFF;
        case (r_state)
            RSP_IDLE: begin
                if (req_read && req_write) begin
                    w_illegal    = ON;
                    w_state_next = RSP_RESP;
                end else if (req_read || req_write) begin
                    w_accept     = ON;
                    w_state_next = RSP_ACCESS;
                end
            end
            RSP_ACCESS: begin
                if (m_ack) begin
                    w_ack_done   = ON;
                    w_state_next = RSP_RESP;
                end else if (w_tc) begin
                    w_timeout    = ON;
                    w_state_next = RSP_RESP;
                end
            end
            RSP_RESP: begin
                w_state_next = RSP_IDLE;
            end
            default: begin
                w_state_next = RSP_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = (r_state == RSP_IDLE);
        resp_valid = (r_state == RSP_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_rd     <= OFF;
            r_m_wr     <= OFF;
            r_dst      <= DST_PC;
            r_is_write <= OFF;
            r_inst     <= '0;
            r_mdr      <= '0;
            r_resp_err <= OFF;
        end else begin
            r_resp_err <= w_illegal || w_timeout;
            if (w_accept) begin
                r_m_addr   <= req_addr;
                r_m_wdata  <= req_wdata;
                r_dst      <= mem_dst_t'(req_dst);
                r_is_write <= req_write;
                r_m_rd     <= req_read;
                r_m_wr     <= req_write;
            end
            if (w_ack_done || w_timeout) begin
                r_m_rd <= OFF;
                r_m_wr <= OFF;
            end
            // Read data lands in exactly one register, chosen by the address source.
            if (w_ack_done && !r_is_write) begin
                if (r_dst == DST_PC) begin
                    r_inst <= m_rdata;
                end else begin
                    r_mdr <= m_rdata;
                end
            end
        end
    end

    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_rd     = r_m_rd;
    assign m_wr     = r_m_wr;
    assign inst_reg = r_inst;
    assign mdr      = r_mdr;
    assign resp_err = r_resp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: fetch, load, store, timeout, illegal,
// busy and mid-access reset sequences with hand-computed expectations.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_read;
    logic        req_write;
    logic        req_dst;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [15:0] inst_reg;
    logic [15:0] mdr;
    logic [15:0] m_addr;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_ack;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder #(
        .WORD_W  (16),
        .ADDR_W  (16),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_dst    (req_dst),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .inst_reg   (inst_reg),
        .mdr        (mdr),
        .m_addr     (m_addr),
        .m_rd       (m_rd),
        .m_wr       (m_wr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_req();
        req_read  = 1'b0;
        req_write = 1'b0;
        m_ack     = 1'b0;
    endtask

    initial begin
        int cyc;
        int pulses;

        reset = 1'b1; req_read = 1'b0; req_write = 1'b0; req_dst = 1'b0;
        req_addr = '0; req_wdata = '0; m_rdata = '0; m_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready",   req_ready,  1);
        chk("rst_valid",   resp_valid, 0);
        chk("rst_err",     resp_err,   0);
        chk("rst_rd",      m_rd,       0);
        chk("rst_wr",      m_wr,       0);
        chk("rst_addr",    m_addr,     0);
        chk("rst_wdata",   m_wdata,    0);
        chk("rst_inst",    inst_reg,   0);
        chk("rst_mdr",     mdr,        0);
        $display("reset: ready=%0d inst=%h mdr=%h", req_ready, inst_reg, mdr);

        // Fetch, ack on the second ACCESS cycle
        req_read = 1'b1; req_dst = 1'b0; req_addr = 16'h0010;
        tick();
        chk("fetch_rd1",   m_rd,      1);
        chk("fetch_busy",  req_ready, 0);
        chk("fetch_addr",  m_addr,    16'h0010);
        tick();
        chk("fetch_rd2",   m_rd,      1);
        m_ack = 1'b1; m_rdata = 16'h6A05;
        tick();
        chk("fetch_valid", resp_valid, 1);
        chk("fetch_err",   resp_err,   0);
        chk("fetch_rd_lo", m_rd,       0);
        chk("fetch_inst",  inst_reg,   16'h6A05);
        chk("fetch_mdr",   mdr,        0);
        drop_req();
        tick();
        chk("fetch_pulse", resp_valid, 0);
        chk("fetch_idle",  req_ready,  1);
        $display("fetch: inst=%h mdr=%h", inst_reg, mdr);

        // Load; ack already high in IDLE must be ignored there
        req_read = 1'b1; req_dst = 1'b1; req_addr = 16'h0100;
        m_ack = 1'b1; m_rdata = 16'hBEEF;
        tick();
        chk("load_rd",     m_rd,       1);
        chk("load_novld",  resp_valid, 0);
        chk("load_mdr0",   mdr,        0);
        tick();
        chk("load_valid",  resp_valid, 1);
        chk("load_mdr",    mdr,        16'hBEEF);
        chk("load_inst",   inst_reg,   16'h6A05);
        drop_req();
        tick();
        $display("load: inst=%h mdr=%h", inst_reg, mdr);

        // Store, ack on the third ACCESS cycle
        req_write = 1'b1; req_addr = 16'h0200; req_wdata = 16'h1234;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("store_wr",    m_wr,    1);
            chk("store_rd",    m_rd,    0);
            chk("store_addr",  m_addr,  16'h0200);
            chk("store_wdata", m_wdata, 16'h1234);
            chk("store_valid0", resp_valid, 0);
            if (i == 2) begin
                m_ack = 1'b1; m_rdata = 16'hFFFF;
            end
            tick();
        end
        chk("store_valid", resp_valid, 1);
        chk("store_err",   resp_err,   0);
        chk("store_wr_lo", m_wr,       0);
        chk("store_inst",  inst_reg,   16'h6A05);
        chk("store_mdr",   mdr,        16'hBEEF);
        drop_req();
        tick();
        $display("store: addr=%h wdata=%h", m_addr, m_wdata);

        // Timeout: no ack ever
        req_read = 1'b1; req_dst = 1'b1; req_addr = 16'h0300;
        tick();
        cyc = m_rd ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!m_rd) break;
            cyc++;
        end
        chk("to_cycles",   cyc,        15);
        chk("to_valid",    resp_valid, 1);
        chk("to_err",      resp_err,   1);
        chk("to_inst",     inst_reg,   16'h6A05);
        chk("to_mdr",      mdr,        16'hBEEF);
        drop_req();
        tick();
        chk("to_err_clr",  resp_err,   0);
        chk("to_idle",     req_ready,  1);
        $display("timeout: strobe cycles=%0d", cyc);

        // Illegal: read and write together
        req_read = 1'b1; req_write = 1'b1; req_addr = 16'h0400;
        tick();
        chk("ill_valid",   resp_valid, 1);
        chk("ill_err",     resp_err,   1);
        chk("ill_rd",      m_rd,       0);
        chk("ill_wr",      m_wr,       0);
        drop_req();
        tick();
        chk("ill_idle",    req_ready,  1);
        $display("illegal: done");

        // Busy: a changed request during ACCESS must not be taken
        req_read = 1'b1; req_dst = 1'b0; req_addr = 16'h0040;
        tick();
        req_addr = 16'h0050; req_wdata = 16'h5555;
        tick();
        chk("busy_addr",   m_addr,  16'h0040);
        chk("busy_wdata",  m_wdata, 16'h1234);
        m_ack = 1'b1; m_rdata = 16'h1111;
        tick();
        pulses = resp_valid ? 1 : 0;
        chk("busy_inst",   inst_reg, 16'h1111);
        drop_req();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid) pulses++;
        end
        chk("busy_pulses", pulses, 1);
        $display("busy: pulses=%0d", pulses);

        // Reset in the middle of an access
        req_read = 1'b1; req_dst = 1'b1; req_addr = 16'h0060;
        tick();
        chk("mrst_rd1",    m_rd, 1);
        reset = 1'b1; req_read = 1'b0;
        tick();
        reset = 1'b0;
        chk("mrst_rd",     m_rd,       0);
        chk("mrst_ready",  req_ready,  1);
        chk("mrst_valid",  resp_valid, 0);
        chk("mrst_inst",   inst_reg,   0);
        chk("mrst_mdr",    mdr,        0);
        chk("mrst_addr",   m_addr,     0);
        m_ack = 1'b1; m_rdata = 16'h2222;
        tick();
        chk("mrst_lateack", resp_valid, 0);
        chk("mrst_mdr2",   mdr,        0);
        m_ack = 1'b0;
        tick();
        chk("mrst_valid2", resp_valid, 0);
        $display("reset mid-access: ready=%0d mdr=%h", req_ready, mdr);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
